// File: rtl/regfile_scoreboard_if.sv
// Register-file / scoreboard port bundle: write, issue and two read ports.
interface regfile_scoreboard_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_addr;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              rd_busy_a;
  logic              rd_busy_b;
  logic [ADDR_W:0]   busy_cnt;
  logic              iss_err;

  modport master (
    output wr_en, wr_addr, wr_data, iss_en, iss_addr, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, busy_cnt, iss_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, iss_en, iss_addr, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, busy_cnt, iss_err
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with per-entry busy scoreboard and two async read ports.
// Optional write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_scoreboard_rdport #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1,
  parameter int DEPTH    = 8
) (
  input  logic [ADDR_W-1:0]            addr_i,
  input  logic [DEPTH-1:0][DATA_W-1:0] mem_i,
  input  logic [DEPTH-1:0]             busy_i,
`ifdef REGFILE_BYPASS_EN
  input  logic                         wr_en_i,
  input  logic [ADDR_W-1:0]            wr_addr_i,
  input  logic [DATA_W-1:0]            wr_data_i,
`endif
  output logic [DATA_W-1:0]            data_o,
  output logic                         busy_o
);
  always_comb begin
    data_o = mem_i[addr_i];
    busy_o = busy_i[addr_i];
`ifdef REGFILE_BYPASS_EN
    // in-flight write resolves the hazard this cycle
    if (wr_en_i && (wr_addr_i == addr_i)) begin
      data_o = wr_data_i;
      busy_o = 1'b0;
    end
`endif
    if ((ZERO_REG != 0) && (addr_i == '0)) begin
      data_o = '0;
      busy_o = 1'b0;
    end
  end
endmodule

module regfile_scoreboard #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1
) (
  input logic                 clk,
  input logic                 rst,
  regfile_scoreboard_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int NPORT = 2;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]             busy_q, busy_d;
  logic [ADDR_W:0]              cnt_q, cnt_d;
  logic                         err_q, err_d;
  logic                         wr_ok, iss_ok;

  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    cnt_d  = '0;
    wr_ok  = bus.wr_en  && !((ZERO_REG != 0) && (bus.wr_addr  == '0));
    iss_ok = bus.iss_en && !((ZERO_REG != 0) && (bus.iss_addr == '0));
    if (wr_ok) begin
      mem_d[bus.wr_addr]  = bus.wr_data;
      busy_d[bus.wr_addr] = 1'b0;
    end
    // issue applied after write so a same-address pair leaves the entry busy
    if (iss_ok) busy_d[bus.iss_addr] = 1'b1;
    err_d = iss_ok && busy_q[bus.iss_addr] &&
            !(wr_ok && (bus.wr_addr == bus.iss_addr));
    for (int i = 0; i < DEPTH; i++)
      cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q  <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  logic [NPORT-1:0][ADDR_W-1:0] rd_addr;
  logic [NPORT-1:0][DATA_W-1:0] rd_data;
  logic [NPORT-1:0]             rd_busy;

  assign rd_addr[0] = bus.rd_addr_a;
  assign rd_addr[1] = bus.rd_addr_b;

  for (genvar g = 0; g < NPORT; g++) begin : g_rd
    regfile_scoreboard_rdport #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .DEPTH(DEPTH)
    ) u_rd (
      .addr_i    (rd_addr[g]),
      .mem_i     (mem_q),
      .busy_i    (busy_q),
`ifdef REGFILE_BYPASS_EN
      .wr_en_i   (bus.wr_en),
      .wr_addr_i (bus.wr_addr),
      .wr_data_i (bus.wr_data),
`endif
      .data_o    (rd_data[g]),
      .busy_o    (rd_busy[g])
    );
  end

  assign bus.rd_data_a = rd_data[0];
  assign bus.rd_data_b = rd_data[1];
  assign bus.rd_busy_a = rd_busy[0];
  assign bus.rd_busy_b = rd_busy[1];
  assign bus.busy_cnt  = cnt_q;
  assign bus.iss_err   = err_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard; expectations follow REGFILE_BYPASS_EN.
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  regfile_scoreboard_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  regfile_scoreboard #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // inputs change 1ns after the edge; outputs are sampled 4ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en  = 1'b0;
    bus.iss_en = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
  endtask

  task automatic iss(input logic [2:0] a);
    bus.iss_en = 1'b1; bus.iss_addr = a;
  endtask

  task automatic rd(input logic [2:0] a, input logic [2:0] b);
    bus.rd_addr_a = a; bus.rd_addr_b = b;
    #4;
  endtask

  task automatic chk_all_clear(input string tag);
    for (int i = 0; i < 8; i++) begin
      rd(i[2:0], 3'(7 - i));
      chk({tag, "_da"}, 32'(bus.rd_data_a), 32'h0);
      chk({tag, "_db"}, 32'(bus.rd_data_b), 32'h0);
      chk({tag, "_ba"}, 32'(bus.rd_busy_a), 32'h0);
      chk({tag, "_bb"}, 32'(bus.rd_busy_b), 32'h0);
    end
    chk({tag, "_cnt"}, 32'(bus.busy_cnt), 32'd0);
    chk({tag, "_err"}, 32'(bus.iss_err), 32'd0);
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.iss_en = 1'b0; bus.iss_addr = '0;
    bus.rd_addr_a = '0; bus.rd_addr_b = '0;
    tick(); tick();
    rst = 1'b0;
    chk_all_clear("reset");

    // write r3, then r0 is discarded
    wr(3'd3, 16'hBEEF); tick(); idle();
    rd(3'd3, 3'd0);
    chk("wr_r3_a", 32'(bus.rd_data_a), 32'hBEEF);
    chk("wr_r3_b0", 32'(bus.rd_data_b), 32'h0);
    wr(3'd0, 16'h1234); tick(); idle();
    rd(3'd0, 3'd3);
    chk("r0_zero", 32'(bus.rd_data_a), 32'h0);
    chk("r3_portb", 32'(bus.rd_data_b), 32'hBEEF);

    // issue r5, re-issue raises iss_err for one cycle, write clears
    iss(3'd5); tick(); idle();
    rd(3'd5, 3'd5);
    chk("r5_busy", 32'(bus.rd_busy_a), 32'd1);
    chk("r5_cnt1", 32'(bus.busy_cnt), 32'd1);
    chk("r5_noerr", 32'(bus.iss_err), 32'd0);
    iss(3'd5); tick(); idle();
    rd(3'd5, 3'd0);
    chk("r5_err", 32'(bus.iss_err), 32'd1);
    chk("r5_cnt_hold", 32'(bus.busy_cnt), 32'd1);
    tick();
    rd(3'd5, 3'd0);
    chk("r5_err_pulse", 32'(bus.iss_err), 32'd0);
    wr(3'd5, 16'h00AA); tick(); idle();
    rd(3'd5, 3'd0);
    chk("r5_clr_busy", 32'(bus.rd_busy_a), 32'd0);
    chk("r5_clr_cnt", 32'(bus.busy_cnt), 32'd0);
    chk("r5_data", 32'(bus.rd_data_a), 32'h00AA);

    // same-cycle issue+write to r2: issue wins, data written
    iss(3'd2); wr(3'd2, 16'h5555); tick(); idle();
    rd(3'd2, 3'd2);
    chk("r2_data", 32'(bus.rd_data_a), 32'h5555);
    chk("r2_busy", 32'(bus.rd_busy_b), 32'd1);
    chk("r2_cnt", 32'(bus.busy_cnt), 32'd1);
    chk("r2_noerr", 32'(bus.iss_err), 32'd0);

    // forwarding: r4 holds 0x1111 and is busy, then written with 0xCAFE
    wr(3'd4, 16'h1111); tick(); idle();
    iss(3'd4); tick(); idle();
    rd(3'd4, 3'd2);
    chk("r4_cnt2", 32'(bus.busy_cnt), 32'd2);
    wr(3'd4, 16'hCAFE);
    rd(3'd4, 3'd4);
`ifdef REGFILE_BYPASS_EN
    chk("byp_data", 32'(bus.rd_data_a), 32'hCAFE);
    chk("byp_busy", 32'(bus.rd_busy_b), 32'd0);
`else
    chk("nobyp_data", 32'(bus.rd_data_a), 32'h1111);
    chk("nobyp_busy", 32'(bus.rd_busy_b), 32'd1);
`endif
    tick(); idle();
    rd(3'd4, 3'd4);
    chk("r4_after", 32'(bus.rd_data_b), 32'hCAFE);
    chk("r4_after_busy", 32'(bus.rd_busy_a), 32'd0);
    chk("r4_cnt1", 32'(bus.busy_cnt), 32'd1);

    // re-issue busy r2 with same-cycle write to r2: no error, stays busy
    iss(3'd2); wr(3'd2, 16'h7777); tick(); idle();
    rd(3'd2, 3'd3);
    chk("r2_reiss_err", 32'(bus.iss_err), 32'd0);
    chk("r2_reiss_busy", 32'(bus.rd_busy_a), 32'd1);
    chk("r2_reiss_data", 32'(bus.rd_data_a), 32'h7777);
    chk("r3_kept", 32'(bus.rd_data_b), 32'hBEEF);

    // issues to r0 are dropped and never flag an error
    iss(3'd0); tick(); iss(3'd0); tick(); idle();
    rd(3'd0, 3'd0);
    chk("r0_iss_busy", 32'(bus.rd_busy_a), 32'd0);
    chk("r0_iss_err", 32'(bus.iss_err), 32'd0);
    chk("r0_iss_cnt", 32'(bus.busy_cnt), 32'd1);

    // issue r7 and write r6 in the same cycle
    iss(3'd7); wr(3'd6, 16'h6666); tick(); idle();
    rd(3'd7, 3'd6);
    chk("r7_busy", 32'(bus.rd_busy_a), 32'd1);
    chk("r6_data", 32'(bus.rd_data_b), 32'h6666);
    chk("r6_busy", 32'(bus.rd_busy_b), 32'd0);
    chk("cnt_r2r7", 32'(bus.busy_cnt), 32'd2);

    // pile up busy entries, then reset wins over a write to r1 and an issue
    iss(3'd1); tick(); iss(3'd6); tick(); idle();
    rd(3'd1, 3'd6);
    chk("pre_rst_cnt", 32'(bus.busy_cnt), 32'd4);
    rst = 1'b1; wr(3'd1, 16'h9999); iss(3'd3); tick();
    rst = 1'b0; idle();
    chk_all_clear("rst_mid");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
